maf_issue_arb: RTL and testbench

- Issue controller for the fused multiply-add (MAF) pipeline.
- Arbitrates two requesters round-robin onto the single datapath issue port.
- Tracks in-flight ops with a LAT-deep tag shift register, captures results/trap codes into a response FIFO, and returns them with the source ID.
- Credit-based issue guarantees no result is ever lost: the datapath cannot stall.

---
 rtl/maf_pkg.sv | 19 +
 rtl/maf_issue_arb_if.sv | 49 ++++
 rtl/maf_rsp_fifo.sv | 57 +++++
 rtl/maf_issue_arb.sv | 110 +++++++++++
 tb/tb_maf_issue_arb.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maf_pkg.sv
// Shared widths and entry types for the MAF issue controller.
package maf_pkg;

   localparam int MAF_CONT_W = 3;
   localparam int MAF_DATA_W = 32;
   localparam int MAF_TRAP_W = 3;

   typedef struct packed {
      logic                  src;
      logic [MAF_TRAP_W-1:0] trap;
      logic [MAF_DATA_W-1:0] data;
   } maf_rsp_t;

   typedef struct packed {
      logic valid;
      logic src;
   } maf_tag_t;

endpackage

// File: rtl/maf_issue_arb_if.sv
// Requester, datapath and response signals of the MAF issue controller.
interface maf_issue_arb_if;
   import maf_pkg::*;

   logic                  req0_valid;
   logic                  req0_ready;
   logic [MAF_CONT_W-1:0] req0_cont;
   logic [MAF_DATA_W-1:0] req0_a;
   logic [MAF_DATA_W-1:0] req0_b;
   logic [MAF_DATA_W-1:0] req0_c;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [MAF_CONT_W-1:0] req1_cont;
   logic [MAF_DATA_W-1:0] req1_a;
   logic [MAF_DATA_W-1:0] req1_b;
   logic [MAF_DATA_W-1:0] req1_c;
   logic                  dp_valid;
   logic [MAF_CONT_W-1:0] dp_cont;
   logic [MAF_DATA_W-1:0] dp_a;
   logic [MAF_DATA_W-1:0] dp_b;
   logic [MAF_DATA_W-1:0] dp_c;
   logic [MAF_DATA_W-1:0] dp_result;
   logic [MAF_TRAP_W-1:0] dp_trap;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_src;
   logic [MAF_DATA_W-1:0] rsp_data;
   logic [MAF_TRAP_W-1:0] rsp_trap;
   logic                  busy;

   modport slave (
      input  req0_valid, req0_cont, req0_a, req0_b, req0_c,
      input  req1_valid, req1_cont, req1_a, req1_b, req1_c,
      input  dp_result, dp_trap, rsp_ready,
      output req0_ready, req1_ready,
      output dp_valid, dp_cont, dp_a, dp_b, dp_c,
      output rsp_valid, rsp_src, rsp_data, rsp_trap, busy
   );

   modport master (
      output req0_valid, req0_cont, req0_a, req0_b, req0_c,
      output req1_valid, req1_cont, req1_a, req1_b, req1_c,
      output dp_result, dp_trap, rsp_ready,
      input  req0_ready, req1_ready,
      input  dp_valid, dp_cont, dp_a, dp_b, dp_c,
      input  rsp_valid, rsp_src, rsp_data, rsp_trap, busy
   );

endinterface

// File: rtl/maf_rsp_fifo.sv
// First-word-fall-through response FIFO; count feeds the issue credit check.
module maf_rsp_fifo
   import maf_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         push,
   input  maf_rsp_t                     push_entry,
   input  logic                         pop,
   output logic                         valid,
   output maf_rsp_t                     head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   maf_rsp_t             mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 do_pop;
   logic                 full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid  = (count != '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign do_pop = pop & valid;
   // Gate with valid so the unreset storage never shows up on the outputs.
   assign head   = valid ? mem[rd_ptr] : '0;

   // NOTE: storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // A push while full is only legal when the head leaves on the same edge.
   assert property (@(posedge clk) disable iff (!rstn) !(push && !do_pop && full));

endmodule

// File: rtl/maf_issue_arb.sv
// MAF issue controller: round-robin arbiter, credit-gated issue, tag pipe, response FIFO.
// Optional MAF_TRAP_HOLD_EN: a trapped result blocks new issue until it is popped.
module maf_issue_arb
   import maf_pkg::*;
#(
   parameter int LAT        = 5,
   parameter int FIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rstn,
   maf_issue_arb_if.slave bus
);

   localparam int OUT_W = $clog2(LAT + FIFO_DEPTH + 2);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   maf_tag_t         tag_q [1:LAT];
   logic             dp_src;
   logic             last_src;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_valid;
   maf_rsp_t         fifo_head;
   maf_rsp_t         push_entry;
   logic             push;
   logic             pop;
   logic [OUT_W-1:0] outstanding;
   logic             can_issue;
   logic             grant0;
   logic             hold;
   logic             issue0;
   logic             issue1;
   logic             handshake;

   // Credit counts everything that will eventually occupy a FIFO slot.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      outstanding = OUT_W'(fifo_count) + OUT_W'(bus.dp_valid);
      for (int i = 1; i <= LAT; i++) outstanding = outstanding + OUT_W'(tag_q[i].valid);
   end

   // On a tie (both or neither valid) the requester not granted last wins.
   assign grant0    = (bus.req0_valid & ~bus.req1_valid)
                    | ((bus.req0_valid ~^ bus.req1_valid) & last_src);
   assign can_issue = (outstanding < OUT_W'(FIFO_DEPTH)) & ~hold;

   assign bus.req0_ready = can_issue & grant0;
   assign bus.req1_ready = can_issue & ~grant0;
   assign issue0         = bus.req0_valid & bus.req0_ready;
   assign issue1         = bus.req1_valid & bus.req1_ready;
   assign handshake      = issue0 | issue1;

   assign push       = tag_q[LAT].valid;
   assign push_entry = '{src: tag_q[LAT].src, trap: bus.dp_trap, data: bus.dp_result};
   assign pop        = fifo_valid & bus.rsp_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.dp_valid <= 1'b0;
         bus.dp_cont  <= '0;
         bus.dp_a     <= '0;
         bus.dp_b     <= '0;
         bus.dp_c     <= '0;
         bus.busy     <= 1'b0;
         dp_src       <= 1'b0;
         last_src     <= 1'b1;
         for (int i = 1; i <= LAT; i++) tag_q[i] <= '0;
      end else begin
         bus.dp_valid <= handshake;
         if (handshake) begin
            dp_src      <= issue1;
            last_src    <= issue1;
            bus.dp_cont <= issue1 ? bus.req1_cont : bus.req0_cont;
            bus.dp_a    <= issue1 ? bus.req1_a    : bus.req0_a;
            bus.dp_b    <= issue1 ? bus.req1_b    : bus.req0_b;
            bus.dp_c    <= issue1 ? bus.req1_c    : bus.req0_c;
         end
         tag_q[1] <= '{valid: bus.dp_valid, src: dp_src};
         for (int i = 2; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
         // The tag leaving stage LAT becomes the push, so only issue and pop change the total.
         bus.busy <= (outstanding + OUT_W'(handshake) - OUT_W'(pop)) != '0;
      end
   end

`ifdef MAF_TRAP_HOLD_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 hold <= 1'b0;
      else if (push && push_entry.trap != '0)    hold <= 1'b1;
      else if (pop && fifo_head.trap != '0)      hold <= 1'b0;
   end
`else
   assign hold = 1'b0;
`endif

   maf_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .valid      (fifo_valid),
      .head       (fifo_head),
      .count      (fifo_count)
   );

   assign bus.rsp_valid = fifo_valid;
   assign bus.rsp_src   = fifo_head.src;
   assign bus.rsp_data  = fifo_head.data;
   assign bus.rsp_trap  = fifo_head.trap;

endmodule

// File: tb/tb_maf_issue_arb.sv
// Self-checking bench for maf_issue_arb against a queue-based transaction model.
module tb_maf_issue_arb;
   import maf_pkg::*;

   localparam int LAT        = 5;
   localparam int FIFO_DEPTH = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   maf_issue_arb_if bus ();

   maf_issue_arb #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic        src;
      logic [31:0] data;
      logic [2:0]  trap;
      int          due;
   } op_t;

   op_t         inflight[$];
   op_t         rsp_q[$];
   logic        m_last;
   logic        m_hold;
   logic        m_dp_valid;
   logic [2:0]  m_dp_cont;
   logic [31:0] m_dp_a, m_dp_b, m_dp_c;
   logic        sched_v [16];
   logic [31:0] sched_r [16];
   logic [2:0]  sched_t [16];
   int          cyc;
   int          checks;
   int          passed;
   int          fails;
   int          hs_obs;

   // Behavioural datapath: result and trap derived from the issued operation.
   function automatic logic [31:0] dp_fn(input logic [2:0] cont, input logic [31:0] a, b, c);
      return a + b + c + {29'd0, cont};
   endfunction

   function automatic logic [2:0] trap_fn(input logic [31:0] c);
      return (c[31:29] == 3'b101) ? 3'b100 : 3'b000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_zero(input string ph);
      check({ph, "_dp_valid"},  32'(bus.dp_valid),  32'd0);
      check({ph, "_dp_cont"},   32'(bus.dp_cont),   32'd0);
      check({ph, "_dp_a"},      bus.dp_a,           32'd0);
      check({ph, "_dp_b"},      bus.dp_b,           32'd0);
      check({ph, "_dp_c"},      bus.dp_c,           32'd0);
      check({ph, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({ph, "_rsp_src"},   32'(bus.rsp_src),   32'd0);
      check({ph, "_rsp_data"},  bus.rsp_data,       32'd0);
      check({ph, "_rsp_trap"},  32'(bus.rsp_trap),  32'd0);
      check({ph, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   task automatic model_reset();
      inflight.delete();
      rsp_q.delete();
      m_last     = 1'b1;
      m_hold     = 1'b0;
      m_dp_valid = 1'b0;
      m_dp_cont  = '0;
      m_dp_a     = '0;
      m_dp_b     = '0;
      m_dp_c     = '0;
      for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
   endtask

   task automatic set_req(input int n, input logic v, input logic [2:0] cont,
                          input logic [31:0] a, b, c);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_cont = cont;
         bus.req0_a = a; bus.req0_b = b; bus.req0_c = c;
      end else begin
         bus.req1_valid = v; bus.req1_cont = cont;
         bus.req1_a = a; bus.req1_b = b; bus.req1_c = c;
      end
   endtask

   task automatic rand_req(input int n, input logic v);
      set_req(n, v, 3'($urandom), $urandom, $urandom, $urandom);
   endtask

   // One clock cycle: drive datapath return, compare, advance model, cross the edge.
   task automatic step();
      int   slot;
      logic can, g1, e0, e1, src;
      op_t  op;
      slot = cyc % 16;
      if (sched_v[slot]) begin
         bus.dp_result = sched_r[slot];
         bus.dp_trap   = sched_t[slot];
         sched_v[slot] = 1'b0;
      end else begin
         bus.dp_result = $urandom;
         bus.dp_trap   = 3'($urandom);
      end
      #1;
      can = ((inflight.size() + rsp_q.size()) < FIFO_DEPTH) && !m_hold;
      if (bus.req0_valid && !bus.req1_valid)      g1 = 1'b0;
      else if (bus.req1_valid && !bus.req0_valid) g1 = 1'b1;
      else                                        g1 = !m_last;
      e0 = can & !g1;
      e1 = can & g1;

      check("req0_ready", 32'(bus.req0_ready), 32'(e0));
      check("req1_ready", 32'(bus.req1_ready), 32'(e1));
      check("dp_valid",   32'(bus.dp_valid),   32'(m_dp_valid));
      check("dp_cont",    32'(bus.dp_cont),    32'(m_dp_cont));
      check("dp_a",       bus.dp_a,            m_dp_a);
      check("dp_b",       bus.dp_b,            m_dp_b);
      check("dp_c",       bus.dp_c,            m_dp_c);
      check("busy",       32'(bus.busy),       32'((inflight.size() + rsp_q.size()) != 0));
      check("rsp_valid",  32'(bus.rsp_valid),  32'(rsp_q.size() != 0));
      if (rsp_q.size() != 0) begin
         check("rsp_src",  32'(bus.rsp_src),  32'(rsp_q[0].src));
         check("rsp_data", bus.rsp_data,      rsp_q[0].data);
         check("rsp_trap", 32'(bus.rsp_trap), 32'(rsp_q[0].trap));
      end

      if (bus.dp_valid === 1'b1) begin
         slot = (cyc + LAT) % 16;
         sched_v[slot] = 1'b1;
         sched_r[slot] = dp_fn(bus.dp_cont, bus.dp_a, bus.dp_b, bus.dp_c);
         sched_t[slot] = trap_fn(bus.dp_c);
      end
      if (bus.req0_valid && bus.req0_ready === 1'b1) hs_obs++;

      if (rsp_q.size() != 0 && bus.rsp_ready) begin
         if (rsp_q[0].trap != 3'd0) m_hold = 1'b0;
         void'(rsp_q.pop_front());
      end
      if (inflight.size() != 0 && inflight[0].due == cyc) begin
         op = inflight.pop_front();
         rsp_q.push_back(op);
`ifdef MAF_TRAP_HOLD_EN
         if (op.trap != 3'd0) m_hold = 1'b1;
`endif
      end
      m_dp_valid = 1'b0;
      if ((e0 && bus.req0_valid) || (e1 && bus.req1_valid)) begin
         src        = e1;
         m_dp_cont  = src ? bus.req1_cont : bus.req0_cont;
         m_dp_a     = src ? bus.req1_a    : bus.req0_a;
         m_dp_b     = src ? bus.req1_b    : bus.req0_b;
         m_dp_c     = src ? bus.req1_c    : bus.req0_c;
         m_dp_valid = 1'b1;
         m_last     = src;
         op.src  = src;
         op.data = dp_fn(m_dp_cont, m_dp_a, m_dp_b, m_dp_c);
         op.trap = trap_fn(m_dp_c);
         op.due  = cyc + 1 + LAT;
         inflight.push_back(op);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      n = 0;
      while (n < 100 && (inflight.size() + rsp_q.size()) != 0) begin
         step();
         n++;
      end
      check("drain_bound", 32'(inflight.size() + rsp_q.size()), 32'd0);
      check("drain_busy",  32'(bus.busy), 32'd0);
   endtask

   initial begin
      checks = 0; passed = 0; fails = 0; hs_obs = 0; cyc = 0;
      set_req(0, 1'b0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0);
      bus.rsp_ready = 1'b0;
      bus.dp_result = '0;
      bus.dp_trap   = '0;
      model_reset();

      // Asynchronous reset before any clock edge.
      #1 rstn = 1'b0;
      #1 check_zero("reset");
      @(negedge clk);
      rstn = 1'b1;

      // Single op from req0: expect 2.0 back after LAT+1 cycles.
      set_req(0, 1'b1, 3'b001, 32'h3F80_0000, 32'h007F_FFFF, 32'h0);
      bus.rsp_ready = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      drain();

      // Both requesters valid: alternating grants, one issue per cycle.
      for (int i = 0; i < 20; i++) begin
         rand_req(0, 1'b1);
         rand_req(1, 1'b1);
         step();
      end
      drain();

      // Backpressure: exactly FIFO_DEPTH handshakes, then one per pop.
      bus.rsp_ready = 1'b0;
      hs_obs = 0;
      for (int i = 0; i < 20; i++) begin
         rand_req(0, 1'b1);
         set_req(1, 1'b0, '0, '0, '0, 32'h0);
         bus.req0_c = 32'h0000_1234;
         step();
      end
      check("bp_handshakes", 32'(hs_obs), 32'(FIFO_DEPTH));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("bp_one_more", 32'(hs_obs), 32'(FIFO_DEPTH + 1));
      drain();

      // FIFO at 7 with one in flight, then simultaneous push and pop.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 13; i++) begin
         rand_req(0, 1'b1);
         bus.req0_c = 32'h0;
         step();
      end
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_req(0, 1'b1);
         bus.req0_c = 32'h0;
         step();
      end
      drain();

      // Randomised traffic with random consumer backpressure.
      for (int i = 0; i < 400; i++) begin
         rand_req(0, 1'($urandom_range(0, 3) != 0));
         rand_req(1, 1'($urandom_range(0, 1)));
         bus.rsp_ready = 1'($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      // Trap on the second of three ops; later ops resume after it pops.
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, 3'b010, 32'h10, 32'h20, 32'h0);
      step();
      set_req(0, 1'b1, 3'b011, 32'h11, 32'h21, 32'hA000_0000);
      step();
      set_req(0, 1'b1, 3'b100, 32'h12, 32'h22, 32'h1);
      step();
      bus.req0_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         rand_req(0, 1'b1);
         bus.req0_c = 32'h5;
         step();
      end
      drain();

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) begin
         rand_req(0, 1'b1);
         rand_req(1, 1'b1);
         step();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #2 rstn = 1'b0;
      #1 check_zero("midreset");
      model_reset();
      @(negedge clk);
      cyc++;
      rstn = 1'b1;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1, "timeout");
   end

endmodule
